// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready stream carrying LANES AES states per beat plus a direction bit
// and a sideband tag. The producer side uses the master modport, the consumer
// side uses the slave modport.
interface aes_shift_rows_pipe_if #(
  parameter int LANES = 1,
  parameter int TAG_W = 4
);
  logic                   valid;
  logic                   ready;
  logic                   inv;
  logic [TAG_W-1:0]       tag;
  logic [128*LANES-1:0]   data;

  modport master (output valid, output inv, output tag, output data, input ready);
  modport slave  (input valid, input inv, input tag, input data, output ready);
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows engine. The byte permutation is applied
// combinationally in front of stage 0; DEPTH register stages follow, each
// holding transformed data, direction bit, tag and a valid flag. Backpressure
// ripples combinationally from out_if.ready so a full pipe can accept and
// drain in the same cycle without inserting a bubble.
module aes_shift_rows_pipe #(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  aes_shift_rows_pipe_if.slave  in_if,
  aes_shift_rows_pipe_if.master out_if,
  output logic                 busy_o,
  output logic [2:0]           occupancy_o
);

  localparam int W = 128 * LANES;

  // Byte i = 4c+r sits at [127-8i -: 8]; row r rotates left by r (forward)
  // or right by r (inverse). The 2-bit source column wraps modulo 4 for free.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c - r) : 2'(c + r);
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*int'(src)+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [W-1:0]     xf;
  logic [W-1:0]     data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [DEPTH-1:0] inv_q;
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] load;
  logic [2:0]       occ_q;
  logic [2:0]       occ_d;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;

  // Transform every lane of the incoming beat with the beat's own direction bit.
  always_comb begin
    xf = '0;
    for (int k = 0; k < LANES; k++) begin
      xf[128*k +: 128] = shift_rows(in_if.data[128*k +: 128], in_if.inv);
    end
  end

  // Stage i may load when it is empty or its content moves on this cycle;
  // the last stage moves on out_if.ready, earlier stages when the next one loads.
  always_comb begin : p_advance
    logic chain;
    load  = '0;
    chain = out_if.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      load[i] = !v_q[i] || chain;
      chain   = load[i];
    end
  end

  assign in_ready = load[0] && !flush_i;
  assign in_fire  = in_if.valid && in_ready;
  assign out_fire = v_q[DEPTH-1] && out_if.ready;

  // Occupancy tracks transfers; flush and reset clear it in the register below.
  always_comb begin
    occ_d = occ_q + {2'b00, in_fire} - {2'b00, out_fire};
  end

  // Pipeline registers: shift on load, clear valids on reset or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      inv_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (load[0]) begin
        v_q[0]    <= in_fire;
        data_q[0] <= xf;
        tag_q[0]  <= in_if.tag;
        inv_q[0]  <= in_if.inv;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          v_q[i]    <= v_q[i-1];
          data_q[i] <= data_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          inv_q[i]  <= inv_q[i-1];
        end
      end
      occ_q <= occ_d;
      if (flush_i) begin
        v_q   <= '0;
        occ_q <= '0;
      end
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = v_q[DEPTH-1];
  assign out_if.data  = data_q[DEPTH-1];
  assign out_if.tag   = tag_q[DEPTH-1];
  assign out_if.inv   = inv_q[DEPTH-1];
  assign busy_o       = (occ_q != 3'd0);
  assign occupancy_o  = occ_q;

endmodule
